// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encodings and requester IDs for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_IO   = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_IO  = 1'b1
  } req_id_e;

  // Counter width for a burst limit; a limit of 1 still needs one bit of storage.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_beat_counter.sv
// rtl/arb_beat_counter.sv - saturating per-tenure beat counter with limit-reached flag
module arb_beat_counter
  import dmem_arb_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clear,
  output logic limit
);

  localparam int CW = cnt_width(BURST_LEN);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over increment; hold at the last beat index instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit = (cnt_q == LAST);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU / I/O arbiter for the 32-word data memory; DMEM_ARB_RR_EN selects round-robin tie-break
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              io_req,
  input  logic              io_write,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_rvalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              addr_err
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  arb_state_e state_q, state_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, io_rdata_q, io_rdata_d;
  logic cpu_rvalid_q, cpu_rvalid_d, io_rvalid_q, io_rvalid_d;
  logic addr_err_q, addr_err_d;
  logic cpu_beat, io_beat, cpu_in_range, io_in_range;
  logic burst_limit, tie_to_io;

  assign cpu_beat     = (state_q == ST_CPU) && cpu_req;
  assign io_beat      = (state_q == ST_IO) && io_req;
  assign cpu_in_range = cpu_addr < DEPTH_A;
  assign io_in_range  = io_addr < DEPTH_A;

`ifdef DMEM_ARB_RR_EN
  req_id_e last_gnt_q, last_gnt_d;

  // Remember who was granted most recently; handoffs count as new grants.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (state_d != state_q) begin
      if (state_d == ST_CPU) begin
        last_gnt_d = REQ_CPU;
      end else if (state_d == ST_IO) begin
        last_gnt_d = REQ_IO;
      end
    end
  end

  // Last-grant register; starts as IO so the first tie goes to the CPU.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt_q <= REQ_IO;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  assign tie_to_io = (last_gnt_q == REQ_CPU);
`else
  assign tie_to_io = 1'b0;
`endif

  arb_beat_counter #(
    .BURST_LEN(BURST_LEN)
  ) u_beat_counter (
    .clock (clock),
    .reset (reset),
    .inc   (cpu_beat | io_beat),
    .clear (state_d != state_q),
    .limit (burst_limit)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: direct handoff when the owner drops, forced handoff at the burst limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && io_req) begin
          state_d = tie_to_io ? ST_IO : ST_CPU;
        end else if (cpu_req) begin
          state_d = ST_CPU;
        end else if (io_req) begin
          state_d = ST_IO;
        end
      end
      ST_CPU: begin
        if (!cpu_req) begin
          state_d = io_req ? ST_IO : ST_IDLE;
        end else if (burst_limit && io_req) begin
          state_d = ST_IO;
        end
      end
      ST_IO: begin
        if (!io_req) begin
          state_d = cpu_req ? ST_CPU : ST_IDLE;
        end else if (burst_limit && cpu_req) begin
          state_d = ST_CPU;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory port mux: only a beat drives the memory; out-of-range and in-reset writes are dropped.
  always_comb begin
    mem_address = '0;
    mem_wdata   = '0;
    mem_write   = 1'b0;
    if (cpu_beat) begin
      mem_address = cpu_addr;
      mem_wdata   = cpu_wdata;
      mem_write   = cpu_write && cpu_in_range && !reset;
    end else if (io_beat) begin
      mem_address = io_addr;
      mem_wdata   = io_wdata;
      mem_write   = io_write && io_in_range && !reset;
    end
  end

  // Read capture: data only changes on a read beat of its own requester.
  always_comb begin
    cpu_rdata_d  = cpu_rdata_q;
    io_rdata_d   = io_rdata_q;
    cpu_rvalid_d = cpu_beat && !cpu_write;
    io_rvalid_d  = io_beat && !io_write;
    addr_err_d   = (cpu_beat && !cpu_in_range) || (io_beat && !io_in_range);
    if (cpu_rvalid_d) begin
      cpu_rdata_d = cpu_in_range ? mem_rdata : '0;
    end
    if (io_rvalid_d) begin
      io_rdata_d = io_in_range ? mem_rdata : '0;
    end
  end

  // Read-data, valid and error registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_rdata_q  <= '0;
      io_rdata_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      io_rvalid_q  <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      cpu_rdata_q  <= cpu_rdata_d;
      io_rdata_q   <= io_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      io_rvalid_q  <= io_rvalid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign cpu_gnt    = (state_q == ST_CPU);
  assign io_gnt     = (state_q == ST_IO);
  assign cpu_rdata  = cpu_rdata_q;
  assign io_rdata   = io_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign io_rvalid  = io_rvalid_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter against an ownership/memory model
module tb_dmem_arbiter;

  localparam int BURST = 4;

  logic        clock;
  logic        reset;
  logic        cpu_req, cpu_write, io_req, io_write;
  logic [31:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
  logic        cpu_gnt, cpu_rvalid, io_gnt, io_rvalid;
  logic [31:0] cpu_rdata, io_rdata;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_write, addr_err;

  dmem_arbiter #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(32), .BURST_LEN(BURST)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .io_req(io_req), .io_write(io_write), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rdata(io_rdata), .io_rvalid(io_rvalid),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .addr_err(addr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h0101_0011) ^ 32'h5A5A_0000;
  endfunction

  // Environment memory: written by the DUT, out-of-range reads return garbage the DUT must mask.
  logic [31:0] tb_mem [32];
  logic        env_init;
  always @(posedge clock) begin
    if (env_init) begin
      for (int i = 0; i < 32; i++) tb_mem[i] <= pat(i);
    end else if (mem_write) begin
      tb_mem[mem_address[4:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_address < 32) ? tb_mem[mem_address[4:0]] : (32'hBAD0_0000 ^ mem_address);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  // Reference model: owner 0=none 1=cpu 2=io, run = beats in current tenure.
  logic [31:0] exp_mem [32];
  int          owner, run, last_owner;
  logic [31:0] m_crd, m_ird;
  logic        m_crv, m_irv, m_err;

  task automatic model_reset();
    owner = 0; run = 0; last_owner = 2;
    m_crd = '0; m_ird = '0; m_crv = 1'b0; m_irv = 1'b0; m_err = 1'b0;
  endtask

  // One clock cycle: entered just after a negedge, returns at the following negedge.
  task automatic step(input logic rst, input logic cr, input logic cw, input logic [31:0] ca,
                      input logic [31:0] cd, input logic ir, input logic iw,
                      input logic [31:0] ia, input logic [31:0] id);
    logic bc, bi, beat, ew, inr, xr, yr;
    logic [31:0] ea, ed;
    int nxt;
    reset = rst; cpu_req = cr; cpu_write = cw; cpu_addr = ca; cpu_wdata = cd;
    io_req = ir; io_write = iw; io_addr = ia; io_wdata = id;
    #1;
    bc = (owner == 1) && cr;
    bi = (owner == 2) && ir;
    beat = bc || bi;
    ea = bc ? ca : (bi ? ia : 32'd0);
    ed = bc ? cd : (bi ? id : 32'd0);
    ew = bc ? cw : (bi ? iw : 1'b0);
    inr = ea < 32;
    check("cpu_gnt", cpu_gnt, owner == 1);
    check("io_gnt", io_gnt, owner == 2);
    check("mem_address", mem_address, ea);
    check("mem_wdata", mem_wdata, ed);
    check("mem_write", mem_write, !rst && beat && ew && inr);
    if (rst) begin
      model_reset();
    end else begin
      m_crv = bc && !cw;
      m_irv = bi && !iw;
      m_err = beat && !inr;
      if (m_crv) m_crd = inr ? exp_mem[ea[4:0]] : 32'd0;
      if (m_irv) m_ird = inr ? exp_mem[ea[4:0]] : 32'd0;
      if (beat && ew && inr) exp_mem[ea[4:0]] = ed;
      nxt = owner;
      if (owner == 0) begin
        if (cr && ir) begin
`ifdef DMEM_ARB_RR_EN
          nxt = (last_owner == 1) ? 2 : 1;
`else
          nxt = 1;
`endif
        end else if (cr) nxt = 1;
        else if (ir) nxt = 2;
      end else begin
        xr = (owner == 1) ? cr : ir;
        yr = (owner == 1) ? ir : cr;
        if (!xr) nxt = yr ? 3 - owner : 0;
        else if ((run + 1 >= BURST) && yr) nxt = 3 - owner;
      end
      if (nxt != owner) run = 0;
      else if (beat) run++;
      if (nxt != owner && nxt != 0) last_owner = nxt;
      owner = nxt;
    end
    @(posedge clock);
    @(negedge clock);
    check("cpu_rvalid", cpu_rvalid, m_crv);
    check("io_rvalid", io_rvalid, m_irv);
    check("cpu_rdata", cpu_rdata, m_crd);
    check("io_rdata", io_rdata, m_ird);
    check("addr_err", addr_err, m_err);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    int run_c, max_c;
    reset = 1'b1; env_init = 1'b1;
    cpu_req = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    io_req = 0; io_write = 0; io_addr = 0; io_wdata = 0;
    for (int i = 0; i < 32; i++) exp_mem[i] = pat(i);
    model_reset();
    repeat (2) @(posedge clock);
    env_init = 1'b0;
    @(negedge clock);

    // CPU write 5 then read 5.
    step(1'b0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("t1_rvalid", cpu_rvalid, 1'b1);
    idle_step();

    // Both held: bursts limited to BURST beats.
    run_c = 0; max_c = 0;
    for (int k = 0; k < 26; k++) begin
      if (cpu_gnt) run_c++;
      else run_c = 0;
      if (run_c > max_c) max_c = run_c;
      step(1'b0, 1'b1, 1'b0, 32'($urandom_range(0, 31)), 32'd0,
           1'b1, 1'b0, 32'($urandom_range(0, 31)), 32'd0);
    end
    check("max_cpu_run", 32'(max_c), 32'(BURST));
    idle_step(); idle_step();

    // Ties from IDLE, twice.
    for (int t = 0; t < 2; t++) begin
      step(1'b0, 1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
      idle_step(); idle_step();
    end

    // IO out-of-range write then read.
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd40, 32'h1234_5678);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd40, 32'h1234_5678);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd40, 32'd0);
    check("t4_rdata", io_rdata, 32'd0);
    idle_step();

    // Reset on CPU beat 2.
    step(1'b0, 1'b1, 1'b1, 32'd7, 32'h0000_0077, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'd7, 32'h0000_0077, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'd8, 32'h0000_0088, 1'b0, 1'b0, 32'd0, 32'd0);
    check("t5_gnt", cpu_gnt, 1'b0);
    idle_step();

    // CPU drops while IO waits: direct handoff.
    step(1'b0, 1'b1, 1'b0, 32'd2, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd2, 32'd0, 1'b1, 1'b0, 32'd3, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd3, 32'd0);
    check("t6_io_gnt", io_gnt, 1'b1);
    idle_step();

    // Random traffic with occasional reset.
    for (int k = 0; k < 500; k++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
           32'($urandom_range(0, 40)), $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
           32'($urandom_range(0, 40)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
